// File: rtl/mux_rr_pipe_pkg.sv
// ============================================================================
// Module  : mux_pkg
// Brief   : Mode constants and width helper shared by the mux_rr_pipe slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pkg;

    localparam int MUX_MODE_SEL = 0;
    localparam int MUX_MODE_RR  = 1;

    // Index width for n items; a single item still needs a 1-bit index.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_rr_pipe_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin request arbiter; search starts at ptr and wraps.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SELW     = clog2_min1(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] req,
    input  logic                advance,
    output logic [SELW-1:0]     grant_idx,
    output logic                grant_vld
);

    logic [SELW-1:0] r_ptr;
    logic            w_hi_vld;
    logic            w_lo_vld;
    logic [SELW-1:0] w_hi_idx;
    logic [SELW-1:0] w_lo_idx;

    // Lowest requester at/above ptr wins; otherwise the lowest overall (wrap).
    always_comb begin
        w_hi_vld = 1'b0;
        w_lo_vld = 1'b0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_lo_vld = 1'b1;
                w_lo_idx = SELW'(i);
                if (SELW'(i) >= r_ptr) begin
                    w_hi_vld = 1'b1;
                    w_hi_idx = SELW'(i);
                end
            end
        end
    end

    assign grant_vld = w_lo_vld;
    assign grant_idx = w_hi_vld ? w_hi_idx : w_lo_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance && grant_vld) begin
            r_ptr <= (grant_idx == SELW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_rr_pipe.sv
// ============================================================================
// Module  : mux_rr_pipe
// Brief   : N-channel registered mux with valid/ready, select or round-robin.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_rr_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    parameter  int MODE     = MUX_MODE_SEL,
    localparam int SELW     = clog2_min1(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SELW-1:0]           sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic             w_load_en;
    logic             w_grant_vld;
    logic [SELW-1:0]  w_grant_idx;
    logic [WIDTH-1:0] w_grant_data;
    logic             w_unused_sel;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_chan;

    assign w_load_en = !r_out_valid || out_ready;

    generate
        if (CHANNELS == 1) begin : g_single
            assign w_grant_vld  = in_valid[0];
            assign w_grant_idx  = '0;
            assign w_unused_sel = ^sel;
        end else if (MODE == MUX_MODE_RR) begin : g_rr
            rr_arbiter #(
                .CHANNELS (CHANNELS)
            ) u_arb (
                .clk       (clk),
                .rst_n     (rst_n),
                .req       (in_valid),
                .advance   (w_load_en),
                .grant_idx (w_grant_idx),
                .grant_vld (w_grant_vld)
            );
            assign w_unused_sel = ^sel;
        end else begin : g_sel
            // An out-of-range sel matches no channel and therefore never grants.
            always_comb begin
                w_grant_vld = 1'b0;
                for (int i = 0; i < CHANNELS; i++) begin
                    if (sel == SELW'(i)) begin
                        w_grant_vld = in_valid[i];
                    end
                end
            end
            assign w_grant_idx  = sel;
            assign w_unused_sel = 1'b0;
        end
    endgenerate

    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant_idx == SELW'(i)) begin
                w_grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = w_load_en && w_grant_vld && (w_grant_idx == SELW'(i));
        end
    end

    // Data and channel hold when the stage empties; only valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else if (w_load_en) begin
            r_out_valid <= w_grant_vld;
            if (w_grant_vld) begin
                r_out_data <= w_grant_data;
                r_out_chan <= w_grant_idx;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_pipe.sv
// ============================================================================
// Module  : tb_mux_rr_pipe
// Brief   : Four mux_rr_pipe configurations checked against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_rr_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Per-instance stimulus: 0:MODE0 N=2, 1:MODE1 N=4, 2:MODE0 N=3, 3:MODE0 N=1
    logic [3:0]  iv   [4];
    logic [31:0] id   [4][4];
    logic [1:0]  sv   [4];
    logic        ordy [4];

    logic [63:0]  d0_in_data;  logic [1:0] d0_in_ready; logic       d0_out_chan;
    logic [127:0] d1_in_data;  logic [3:0] d1_in_ready; logic [1:0] d1_out_chan;
    logic [95:0]  d2_in_data;  logic [2:0] d2_in_ready; logic [1:0] d2_out_chan;
    logic [31:0]  d3_in_data;  logic [0:0] d3_in_ready; logic       d3_out_chan;
    logic [31:0]  od [4];
    logic         ov [4];

    assign d0_in_data = {id[0][1], id[0][0]};
    assign d1_in_data = {id[1][3], id[1][2], id[1][1], id[1][0]};
    assign d2_in_data = {id[2][2], id[2][1], id[2][0]};
    assign d3_in_data = id[3][0];

    mux_rr_pipe #(.WIDTH(32), .CHANNELS(2), .MODE(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_data(d0_in_data), .in_valid(iv[0][1:0]),
        .in_ready(d0_in_ready), .sel(sv[0][0:0]), .out_data(od[0]),
        .out_chan(d0_out_chan), .out_valid(ov[0]), .out_ready(ordy[0]));
    mux_rr_pipe #(.WIDTH(32), .CHANNELS(4), .MODE(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_data(d1_in_data), .in_valid(iv[1]),
        .in_ready(d1_in_ready), .sel(sv[1]), .out_data(od[1]),
        .out_chan(d1_out_chan), .out_valid(ov[1]), .out_ready(ordy[1]));
    mux_rr_pipe #(.WIDTH(32), .CHANNELS(3), .MODE(0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_data(d2_in_data), .in_valid(iv[2][2:0]),
        .in_ready(d2_in_ready), .sel(sv[2]), .out_data(od[2]),
        .out_chan(d2_out_chan), .out_valid(ov[2]), .out_ready(ordy[2]));
    mux_rr_pipe #(.WIDTH(32), .CHANNELS(1), .MODE(0)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_valid(iv[3][0:0]),
        .in_ready(d3_in_ready), .sel(sv[3][0:0]), .out_data(od[3]),
        .out_chan(d3_out_chan), .out_valid(ov[3]), .out_ready(ordy[3]));

    logic [1:0] oc [4];
    logic [3:0] ir [4];
    assign oc[0] = {1'b0, d0_out_chan};  assign ir[0] = {2'b00, d0_in_ready};
    assign oc[1] = d1_out_chan;          assign ir[1] = d1_in_ready;
    assign oc[2] = d2_out_chan;          assign ir[2] = {1'b0, d2_in_ready};
    assign oc[3] = {1'b0, d3_out_chan};  assign ir[3] = {3'b000, d3_in_ready};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          v;
        logic [31:0] d;
        int          ch;
        int          ptr;
    } mst_t;

    mst_t        m   [4];
    bit          acc [4];
    logic [31:0] sb_q [$];

    function automatic int n_of(input int k);
        case (k)
            0:       return 2;
            1:       return 4;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int sel_of(input int k);
        return (k == 0) ? int'(sv[0][0]) : int'(sv[k]);
    endfunction

    // Which channel the rules pick right now, or -1 for none.
    function automatic int grant_of(input int k, input int ptr, input logic [3:0] v, input int s);
        int n;
        n = n_of(k);
        if (n == 1) return v[0] ? 0 : -1;
        if (k != 1) return (s < n && v[s]) ? s : -1;
        for (int j = 0; j < n; j++) begin
            if (v[(ptr + j) % n]) return (ptr + j) % n;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 4; k++) begin
            int g;
            acc[k] = 1'b0;
            if (!rst_n) begin
                m[k] = '{1'b0, 32'd0, 0, 0};
            end else if (!m[k].v || ordy[k]) begin
                g = grant_of(k, m[k].ptr, iv[k], sel_of(k));
                if (g >= 0) begin
                    m[k].v   = 1'b1;
                    m[k].d   = id[k][g];
                    m[k].ch  = g;
                    m[k].ptr = (g == n_of(k) - 1) ? 0 : g + 1;
                    acc[k]   = 1'b1;
                    if (k == 3) sb_q.push_back(id[3][0]);
                end else begin
                    m[k].v = 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit          cmp_en = 1'b0;
    logic [31:0] rx_exp;

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            for (int k = 0; k < 4; k++) begin
                int         g;
                logic [3:0] er;
                g  = grant_of(k, m[k].ptr, iv[k], sel_of(k));
                er = 4'b0000;
                if ((!m[k].v || ordy[k]) && g >= 0) er[g] = 1'b1;
                chk($sformatf("d%0d_out_valid", k), 64'(ov[k]), 64'(m[k].v));
                chk($sformatf("d%0d_out_data", k),  64'(od[k]), 64'(m[k].d));
                chk($sformatf("d%0d_out_chan", k),  64'(oc[k]), 64'(m[k].ch));
                chk($sformatf("d%0d_in_ready", k),  64'(ir[k]), 64'(er));
            end
            // Output handshake on the N=1 instance: words must arrive in order, once each.
            if (m[3].v && ordy[3]) begin
                chk("sb_seq", 64'(od[3]), 64'(rx_exp));
                if (sb_q.size() == 0) begin
                    chk("sb_nonempty", 64'(0), 64'(1));
                end else begin
                    chk("sb_front", 64'(od[3]), 64'(sb_q[0]));
                    void'(sb_q.pop_front());
                end
                rx_exp = rx_exp + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int seq_a [5];
        int seq_b [4];
        int tx;
        seq_a = '{0, 1, 2, 3, 0};
        seq_b = '{2, 3, 0, 2};
        rx_exp = 32'd1;
        tx = 0;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            iv[k] = 4'b0; sv[k] = 2'b0; ordy[k] = 1'b0;
            for (int j = 0; j < 4; j++) id[k][j] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(ov[1]), 64'd0);
        chk("rst_out_data",  64'(od[0]), 64'd0);
        chk("rst_out_chan",  64'(oc[1]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        step();

        // select-driven, N=2
        id[0][0] = 32'd100; id[0][1] = 32'd200; iv[0] = 4'b0011; ordy[0] = 1'b1; sv[0] = 2'd0;
        #1 chk("t1_ready", 64'(d0_in_ready), 64'b01);
        step(); chk("t1_data0", 64'(od[0]), 64'd100); chk("t1_chan0", 64'(oc[0]), 64'd0);
        sv[0] = 2'd1;
        step(); chk("t1_data1", 64'(od[0]), 64'd200); chk("t1_chan1", 64'(oc[0]), 64'd1);
        sv[0] = 2'd0;
        step(); chk("t1_data2", 64'(od[0]), 64'd100); chk("t1_valid", 64'(ov[0]), 64'd1);

        // stall holds the word regardless of sel
        ordy[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sv[0] = sv[0] ^ 2'd1;
            #1 chk("t2_ready", 64'(d0_in_ready), 64'b00);
            step(); chk("t2_hold", 64'(od[0]), 64'd100);
        end
        ordy[0] = 1'b1; sv[0] = 2'd1;
        step(); chk("t2_release", 64'(od[0]), 64'd200);
        iv[0] = 4'b0;

        // round-robin, N=4
        for (int i = 0; i < 4; i++) id[1][i] = 32'(10 * (i + 1));
        iv[1] = 4'hF; ordy[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_chan", 64'(oc[1]), 64'(seq_a[i]));
            chk("t3_data", 64'(od[1]), 64'(10 * (seq_a[i] + 1)));
        end
        iv[1] = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_chan_drop", 64'(oc[1]), 64'(seq_b[i]));
        end

        // async reset during a stall
        iv[1] = 4'b0001; id[1][0] = 32'hDEADBEEF;
        step(); chk("t4_load", 64'(od[1]), 64'hDEADBEEF);
        ordy[1] = 1'b0;
        step(); chk("t4_stall", 64'(ov[1]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_valid", 64'(ov[1]), 64'd0);
        chk("t4_rst_data",  64'(od[1]), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        id[1][0] = 32'd10; iv[1] = 4'hF; ordy[1] = 1'b1;
        step(); chk("t4_rr_restart", 64'(oc[1]), 64'd0);
        step(); chk("t4_rr_next", 64'(oc[1]), 64'd1);
        iv[1] = 4'b0;

        // out-of-range sel, N=3
        for (int i = 0; i < 3; i++) id[2][i] = 32'(i + 1);
        iv[2] = 4'b0111; ordy[2] = 1'b1; sv[2] = 2'd0;
        step(); chk("t5_valid", 64'(ov[2]), 64'd1);
        sv[2] = 2'd3;
        #1 chk("t5_oor_ready", 64'(d2_in_ready), 64'b000);
        step(); chk("t5_drain", 64'(ov[2]), 64'd0);
        sv[2] = 2'd2;
        #1 chk("t5_ready2", 64'(d2_in_ready), 64'b100);
        step(); chk("t5_data2", 64'(od[2]), 64'd3); chk("t5_chan2", 64'(oc[2]), 64'd2);
        iv[2] = 4'b0;

        // N=1 random valid/ready
        id[3][0] = 32'd1;
        for (int i = 0; i < 1000; i++) begin
            iv[3]   = 4'($urandom_range(0, 1));
            ordy[3] = 1'($urandom_range(0, 1));
            step();
            if (acc[3]) begin
                tx++;
                id[3][0] = id[3][0] + 1;
            end
        end
        iv[3] = 4'b0; ordy[3] = 1'b1;
        step(); step();
        chk("t6_count", 64'(rx_exp - 1), 64'(tx));
        chk("t6_left",  64'(sb_q.size()), 64'd0);
        chk("t6_busy",  64'(tx > 100), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
